// File: rtl/axi_lite_mem_slave.sv
// -----------------------------------------------------------------------------
// axi_lite_mem_slave
//
// AXI4-Lite responder that turns AW/W/AR transactions into single-cycle
// accesses on a simple synchronous memory/register port and returns B/R
// responses with full valid/ready back-pressure. Only one transaction is in
// flight at a time; writes take priority over reads.
//
// Optional feature (compile-time macro AXI_SLV_RANGE_CHK_EN):
//   When defined, addresses outside [BASE_ADDR, BASE_ADDR+SIZE_BYTES) do not
//   strobe the memory and are answered with SLVERR (reads return zero data).
//   When undefined, every address is accessed and responses are always OKAY.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   s_axi_aw*           write address channel (awprot ignored)
//   s_axi_w*            write data channel (4 byte strobes)
//   s_axi_b*            write response channel
//   s_axi_ar*           read address channel (arprot ignored)
//   s_axi_r*            read data/response channel
//   mem_en_o            one-cycle access strobe
//   mem_we_o            write enable, qualified by mem_en_o
//   mem_addr_o          word-aligned address
//   mem_wdata_o         write data
//   mem_wstrb_o         byte enables
//   mem_rdata_i         read data, valid the cycle after a read strobe
// -----------------------------------------------------------------------------
module axi_lite_mem_slave #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] SIZE_BYTES = 32'h0000_4000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [2:0]        s_axi_awprot,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [2:0]        s_axi_arprot,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_wstrb_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [2:0] {
    IDLE,
    WR_EXEC,
    WR_RESP,
    RD_EXEC,
    RD_WAIT,
    RD_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t            state;
  logic              aw_held;
  logic              w_held;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic              err_q;

  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_err;
  logic              rd_err;
  logic              unused_bits;

  // Readies only in IDLE and never during reset. A read is accepted only when
  // no write is pending or being offered, which gives writes priority.
  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_arready = 1'b0;
    if (!rst && state == IDLE) begin
      s_axi_awready = ~aw_held;
      s_axi_wready  = ~w_held;
      s_axi_arready = ~aw_held & ~w_held & ~s_axi_awvalid & ~s_axi_wvalid;
    end
  end

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid  & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  // The write address being committed is either the held one or the one
  // handshaking in this very cycle.
  assign wr_addr = aw_held ? addr_q : s_axi_awaddr;

  assign mem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = wstrb_q;

`ifdef AXI_SLV_RANGE_CHK_EN
  // One extra bit keeps BASE_ADDR+SIZE_BYTES from wrapping at the top of
  // the address space.
  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] lo;
    logic [ADDR_W:0] hi;
    logic [ADDR_W:0] x;
    lo = {1'b0, BASE_ADDR};
    hi = lo + {1'b0, SIZE_BYTES};
    x  = {1'b0, a};
    return (x < lo) || (x >= hi);
  endfunction

  assign wr_err      = out_of_range(wr_addr);
  assign rd_err      = out_of_range(s_axi_araddr);
  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, addr_q[1:0]};
`else
  assign wr_err      = 1'b0;
  assign rd_err      = 1'b0;
  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, addr_q[1:0],
                         BASE_ADDR, SIZE_BYTES, wr_addr};
`endif

  // Main FSM. The memory strobe is registered on entry to an EXEC state so it
  // is high for exactly that one cycle; an address error just keeps it low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      err_q        <= 1'b0;
      mem_en_o     <= 1'b0;
      mem_we_o     <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
      s_axi_rvalid <= 1'b0;
      s_axi_rresp  <= RESP_OKAY;
      s_axi_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            addr_q  <= s_axi_awaddr;
            aw_held <= 1'b1;
          end
          if (w_hs) begin
            wdata_q <= s_axi_wdata;
            wstrb_q <= s_axi_wstrb;
            w_held  <= 1'b1;
          end
          if ((aw_held | aw_hs) && (w_held | w_hs)) begin
            state    <= WR_EXEC;
            mem_en_o <= ~wr_err;
            mem_we_o <= 1'b1;
            err_q    <= wr_err;
          end else if (ar_hs) begin
            addr_q   <= s_axi_araddr;
            state    <= RD_EXEC;
            mem_en_o <= ~rd_err;
            mem_we_o <= 1'b0;
            err_q    <= rd_err;
          end
        end

        WR_EXEC: begin
          mem_en_o     <= 1'b0;
          mem_we_o     <= 1'b0;
          aw_held      <= 1'b0;
          w_held       <= 1'b0;
          s_axi_bresp  <= err_q ? RESP_SLVERR : RESP_OKAY;
          s_axi_bvalid <= 1'b1;
          state        <= WR_RESP;
        end

        WR_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            state        <= IDLE;
          end
        end

        RD_EXEC: begin
          mem_en_o <= 1'b0;
          state    <= RD_WAIT;
        end

        // The memory presents its data this cycle; capture it so rdata
        // stays stable however long the master stalls.
        RD_WAIT: begin
          s_axi_rdata  <= err_q ? '0 : mem_rdata_i;
          s_axi_rresp  <= err_q ? RESP_SLVERR : RESP_OKAY;
          s_axi_rvalid <= 1'b1;
          state        <= RD_RESP;
        end

        RD_RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            state        <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
